// File: rtl/sample_uart_streamer.sv
// Buffers 16-bit sample words in a small FIFO and sends each one as two 8N1
// UART bytes, low byte first, on a single line.
module sample_uart_streamer #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          MAX10_CLK1_50,
  input  logic                          reset,
  input  logic [15:0]                   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   words_sent
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CPB);
  localparam logic [AW:0]   FULL_LVL  = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  logic [15:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level_next;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic           byte_sel;
  logic [15:0]    tx_word;
  logic           push;
  logic           pop;
  logic           baud_last;

  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && (fifo_level != '0);
  assign baud_last = (baud_cnt == BAUD_LAST);

  always_comb begin
    level_next = fifo_level;
    if (push && !pop)
      level_next = fifo_level + (AW+1)'(1);
    else if (!push && pop)
      level_next = fifo_level - (AW+1)'(1);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_ready   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      in_ready   <= (level_next != FULL_LVL);
    end
  end

  // uart_tx is registered from the current state, so the line trails the FSM
  // by one clock while every bit still lasts exactly CPB cycles.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_sel   <= 1'b0;
      tx_word    <= '0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            tx_word  <= mem[rd_ptr];
            byte_sel <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
            busy     <= 1'b1;
          end else begin
            busy <= (level_next != '0);
          end
        end
        START: begin
          uart_tx <= 1'b0;
          busy    <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          uart_tx <= tx_word[{byte_sel, bit_idx}];
          busy    <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              state    <= START;
              busy     <= 1'b1;
            end else begin
              words_sent <= words_sent + 32'd1;
              state      <= IDLE;
              busy       <= (level_next != '0);
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
            busy     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_uart_streamer.sv
// Directed bench: CLKS_PER_BIT=4, FIFO_DEPTH=4, with a line decoder that
// recovers bytes and start-bit cycle numbers from uart_tx.
module tb_sample_uart_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        uart_tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [31:0] words_sent;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;
  int unsigned max_level  = 0;
  logic [7:0]  rx_q [$];
  int unsigned rx_t [$];

  sample_uart_streamer #(.CLK_HZ(40), .BAUD(10), .FIFO_DEPTH(4)) dut (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .words_sent   (words_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) max_level <= 0;
    else if (fifo_level > max_level) max_level <= fifo_level;
  end

  // Start bit first seen at negedge k; data bit i sampled at k+5+4i, stop at k+37.
  always begin : rx
    logic [7:0]  b;
    int unsigned t0;
    bit          ab;
    @(negedge clk);
    if (reset !== 1'b1 && uart_tx === 1'b0) begin
      t0 = cyc;
      ab = 1'b0;
      b  = '0;
      for (int j = 1; j <= 37; j++) begin
        @(negedge clk);
        if (reset) begin ab = 1'b1; break; end
        if (j >= 5 && j <= 33 && (j % 4) == 1) b[(j-5)/4] = uart_tx;
      end
      if (!ab) begin
        compared++;
        if (uart_tx !== 1'b1) begin
          mismatched++;
          $display("FAIL rx_stop_bit: got %b, want 1 (frame at cycle %0d)", uart_tx, t0);
        end
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic push(input logic [15:0] w);
    bit acc;
    acc      = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      acc = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    compared++;
    if (!acc) begin
      mismatched++;
      $display("FAIL push_timeout: word %h never accepted, want accepted", w);
    end
  endtask

  task automatic wait_words(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (words_sent === target) break;
      @(negedge clk);
    end
    compared++;
    if (words_sent !== target) begin
      mismatched++;
      $display("FAIL words_sent_timeout: got %0d, want %0d", words_sent, target);
    end
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp [$]);
    logic [7:0] got;
    compared++;
    if (rx_q.size() != exp.size()) begin
      mismatched++;
      $display("FAIL %s_count: got %0d bytes, want %0d", name, rx_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin
        mismatched++;
        $display("FAIL %s_byte%0d: got %h, want %h", name, i, got, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    compared += 5;
    if (uart_tx !== 1'b1)     begin mismatched++; $display("FAIL rst_uart_tx: got %b, want 1", uart_tx); end
    if (in_ready !== 1'b0)    begin mismatched++; $display("FAIL rst_in_ready: got %b, want 0", in_ready); end
    if (busy !== 1'b0)        begin mismatched++; $display("FAIL rst_busy: got %b, want 0", busy); end
    if (fifo_level !== 3'd0)  begin mismatched++; $display("FAIL rst_fifo_level: got %0d, want 0", fifo_level); end
    if (words_sent !== 32'd0) begin mismatched++; $display("FAIL rst_words_sent: got %0d, want 0", words_sent); end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_release_in_ready: got %b, want 1", in_ready); end
  endtask

  task automatic test_single();
    int unsigned n;
    logic        pb;
    apply_reset();
    push(16'h12A5);
    n = cyc;
    @(negedge clk);
    compared++;
    if (uart_tx !== 1'b1) begin mismatched++; $display("FAIL single_tx_n1: got %b, want 1", uart_tx); end
    @(negedge clk);
    compared++;
    if (uart_tx !== 1'b0) begin mismatched++; $display("FAIL single_tx_n2: got %b, want 0", uart_tx); end
    pb = busy;
    for (int i = 0; i < 200; i++) begin
      if (words_sent === 32'd1) break;
      pb = busy;
      @(negedge clk);
    end
    compared += 4;
    if (words_sent !== 32'd1) begin mismatched++; $display("FAIL single_words_sent: got %0d, want 1", words_sent); end
    if (cyc != n + 81)        begin mismatched++; $display("FAIL single_done_edge: got %0d, want %0d", cyc, n + 81); end
    if (busy !== 1'b0)        begin mismatched++; $display("FAIL single_busy_after: got %b, want 0", busy); end
    if (pb !== 1'b1)          begin mismatched++; $display("FAIL single_busy_before: got %b, want 1", pb); end
    repeat (4) @(negedge clk);
    check_bytes("single", '{8'hA5, 8'h12});
    compared++;
    if (rx_t.size() != 2 || rx_t[0] != n + 2 || rx_t[1] != n + 42) begin
      mismatched++;
      $display("FAIL single_start_times: got %p, want [%0d %0d]", rx_t, n + 2, n + 42);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned acc [7];
    logic [7:0]  exp [$];
    apply_reset();
    for (int w = 1; w <= 6; w++) begin
      push(16'(w));
      acc[w] = cyc;
      exp.push_back(8'(w));
      exp.push_back(8'h00);
      if (w == 5) begin
        compared += 2;
        if (fifo_level !== 3'd4) begin mismatched++; $display("FAIL b2b_full_level: got %0d, want 4", fifo_level); end
        if (in_ready !== 1'b0)   begin mismatched++; $display("FAIL b2b_full_ready: got %b, want 0", in_ready); end
      end
    end
    compared++;
    if (acc[6] != acc[1] + 83) begin
      mismatched++;
      $display("FAIL b2b_sixth_accept: got %0d, want %0d", acc[6], acc[1] + 83);
    end
    wait_words(32'd6, 600);
    repeat (4) @(negedge clk);
    check_bytes("b2b", exp);
    for (int i = 1; i < 12; i++) begin
      compared++;
      if (i >= rx_t.size() || rx_t[i] - rx_t[i-1] != ((i % 2 == 1) ? 40 : 41)) begin
        mismatched++;
        $display("FAIL b2b_gap%0d: got %0d, want %0d", i,
                 (i < rx_t.size()) ? rx_t[i] - rx_t[i-1] : 0, (i % 2 == 1) ? 40 : 41);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [$];
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(16'h0100 + 16'(i));
      exp.push_back(8'(i));
      exp.push_back(8'h01);
    end
    wait_words(32'd13, 1300);
    repeat (4) @(negedge clk);
    check_bytes("wrap", exp);
    compared++;
    if (max_level != 4) begin mismatched++; $display("FAIL wrap_max_level: got %0d, want 4", max_level); end
  endtask

  task automatic test_simul();
    int unsigned n;
    apply_reset();
    push(16'hA001);
    n = cyc;
    push(16'hB002);
    push(16'hC003);
    compared++;
    if (fifo_level !== 3'd2) begin mismatched++; $display("FAIL simul_level_fill: got %0d, want 2", fifo_level); end
    for (int i = 0; i < 200 && cyc < n + 81; i++) @(negedge clk);
    compared += 2;
    if (fifo_level !== 3'd2)  begin mismatched++; $display("FAIL simul_level_pre: got %0d, want 2", fifo_level); end
    if (words_sent !== 32'd1) begin mismatched++; $display("FAIL simul_words_pre: got %0d, want 1", words_sent); end
    in_data  = 16'hD004;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if (fifo_level !== 3'd2) begin mismatched++; $display("FAIL simul_level_post: got %0d, want 2", fifo_level); end
    @(negedge clk);
    compared++;
    if (uart_tx !== 1'b0) begin mismatched++; $display("FAIL simul_start_bit: got %b, want 0", uart_tx); end
    wait_words(32'd4, 400);
    repeat (4) @(negedge clk);
    check_bytes("simul", '{8'h01, 8'hA0, 8'h02, 8'hB0, 8'h03, 8'hC0, 8'h04, 8'hD0});
  endtask

  task automatic test_reset_mid();
    int unsigned n;
    apply_reset();
    push(16'hBEEF);
    n = cyc;
    push(16'h1111);
    for (int i = 0; i < 100 && cyc < n + 19; i++) @(negedge clk);
    compared++;
    if (fifo_level !== 3'd1) begin mismatched++; $display("FAIL mid_level_pre: got %0d, want 1", fifo_level); end
    #2 reset = 1'b1;
    #1;
    compared += 4;
    if (uart_tx !== 1'b1)    begin mismatched++; $display("FAIL mid_uart_tx: got %b, want 1", uart_tx); end
    if (fifo_level !== 3'd0) begin mismatched++; $display("FAIL mid_fifo_level: got %0d, want 0", fifo_level); end
    if (busy !== 1'b0)       begin mismatched++; $display("FAIL mid_busy: got %b, want 0", busy); end
    if (in_ready !== 1'b0)   begin mismatched++; $display("FAIL mid_in_ready: got %b, want 0", in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rx_q.delete();
    rx_t.delete();
    push(16'h00FF);
    wait_words(32'd1, 200);
    repeat (4) @(negedge clk);
    check_bytes("mid", '{8'hFF, 8'h00});
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    dut.words_sent = 32'hFFFF_FFFF;
    @(negedge clk);
    compared++;
    if (words_sent !== 32'hFFFF_FFFF) begin
      mismatched++;
      $display("FAIL wrap_deposit: got %h, want ffffffff", words_sent);
    end
    push(16'h5A5A);
    wait_words(32'd0, 200);
    repeat (4) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL wrap_busy: got %b, want 0", busy); end
    check_bytes("cwrap", '{8'h5A, 8'h5A});
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_simul();
    test_reset_mid();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sample_uart_streamer.md
Name: sample_uart_streamer

Overview:
Downstream consumer of the `sample` stage. It accepts 16-bit SRAM sample words over a valid/ready interface and buffers them in a small FIFO. It serialises each word as two 8N1 UART bytes, low byte first, on one GPIO pin so a host PC can log power-up snapshots. It also reports FIFO occupancy and a running count of words transmitted.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division; 434 at defaults); must be ≥ 2.
- FIFO_DEPTH, 16, word FIFO depth; power of 2, ≥ 2.

Ports:
- MAX10_CLK1_50  in   1   system clock; all logic is rising-edge.
- reset  in   1   asynchronous, active-high reset.
- in_data  in   16   sample word from `sample`.
- in_valid  in   1   in_data is valid.
- in_ready  out  1   FIFO can accept a word.
- uart_tx  out  1   serial output, idle high; maps to a GPIO pin.
- busy  out  1   high while the FIFO is non-empty or a frame is in flight.
- fifo_level  out  $clog2(FIFO_DEPTH)+1   words currently stored (0..FIFO_DEPTH).
- words_sent  out  32   count of fully transmitted words.

Behaviour:
- Clock and reset: one clock, MAX10_CLK1_50. reset is asynchronous and active-high.
- Reset values (immediate on assertion, held while asserted):
  - uart_tx=1, in_ready=0, busy=0, fifo_level=0, words_sent=0.
  - FIFO pointers cleared, FSM in IDLE.
- After reset release: in_ready=1 from the first clock edge onward.
- Input handshake:
  - A word is accepted on any rising edge where in_valid && in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH), decoded from registered state only; no combinational path from in_valid.
  - in_data must be held stable while in_valid is high and in_ready is low. Data is never dropped or overwritten.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Push and pop on the same edge leave fifo_level unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens on the same edge. in_ready rises on the edge after the pop.
  - Pop while empty cannot occur.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO non-empty, pop the head word into a 16-bit shift register, set byte_sel=0 (low byte), enter START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: uart_tx = selected byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, enter STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_sel=0: set byte_sel=1 and go directly to START (no idle gap between the two bytes of one word);
    - otherwise: increment words_sent (wraps 0xFFFFFFFF→0) and return to IDLE.
- Consecutive words: a queued word leaves IDLE one cycle after the previous STOP ends. Gap between words is exactly 1 idle clock.
- Latency: word accepted into an empty FIFO on edge N → uart_tx low after edge N+2 (N+1 sees non-empty and pops; N+2 drives the start bit).
- Timing:
  - All outputs are registered; uart_tx comes from a flop, so it is glitch-free.
  - Baud counter runs 0..CLKS_PER_BIT-1 and resets on every state or bit change.
  - One word occupies 20·CLKS_PER_BIT cycles of line time.
- busy = (fifo_level != 0) || (state != IDLE).
- Reset mid-frame: the frame is abandoned immediately, uart_tx returns high, FIFO contents are discarded, words_sent clears. No partial byte is resumed after release.

Test Plan:
- Default-mode bench parameters: CLK_HZ=40, BAUD=10, so CLKS_PER_BIT=4.
- Single word: push 0x12A5 into an idle block.
  - uart_tx low 2 edges later.
  - Line carries frame 0 10100101 1, then immediately 0 01001000 1 (bit times of 4 clocks).
  - words_sent=1 after 80 line clocks; busy falls on the same edge.
- Back-pressure with FIFO_DEPTH=4: hold in_valid high with words 0x0001..0x0006.
  - in_ready drops when fifo_level=4 (5th word held until the first pop).
  - All 6 words appear on the line in order.
  - Inter-word idle gap is exactly 1 clock; words_sent ends at 6.
- Wrap-around: stream 3·FIFO_DEPTH+1 incrementing words while the input stalls randomly.
  - Decoded serial output equals the input sequence exactly.
  - fifo_level never exceeds FIFO_DEPTH.
- Simultaneous push/pop: with the FIFO at level 2, push on the same edge that IDLE pops → fifo_level stays 2 on that edge.
- Reset mid-frame: assert reset during DATA bit 3 of word 0xBEEF.
  - uart_tx=1 and fifo_level=0 immediately, without waiting for a clock edge.
  - After release, push 0x00FF → frames 0xFF then 0x00, and words_sent=1.
- Counter wrap: force words_sent to 0xFFFFFFFF via hierarchical deposit, send one word → words_sent=0.
